// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the WISC-16 pipeline hazard
//               scoreboard (in-flight entry record, forward-select encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Default register-specifier width (8 architectural registers)
  localparam int REG_ADDR_W_DEF = 3;

  // Forward-select code meaning "take the operand from the register file"
  localparam int FWD_NONE = 0;

  // One in-flight instruction as seen by the scoreboard
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      is_load;
  } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/sb_match.sv
`default_nettype none
// ============================================================================
// Module      : sb_match
// Description : Matches one decode operand against the forwardable in-flight
//               entries (EX .. WB-1) and priority-encodes the youngest hit.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_match
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int N_ENT      = 2,
  parameter int SEL_W      = 2
) (
  input  logic [N_ENT-1:0]            i_ent_valid,
  input  logic [N_ENT*REG_ADDR_W-1:0] i_ent_rd,
  input  logic                        i_ent0_is_load,
  input  logic [REG_ADDR_W-1:0]       i_op_addr,
  input  logic                        i_op_used,
  output logic                        o_hit,
  output logic                        o_load_hit_entry0,
  output logic [SEL_W-1:0]            o_sel
);

  logic [N_ENT-1:0] w_match;

  // Per-entry match: live entry, operand actually read, same register
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_ENT; i++) begin
      w_match[i] = i_ent_valid[i] && i_op_used &&
                   (i_ent_rd[i*REG_ADDR_W +: REG_ADDR_W] == i_op_addr);
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites the select
  always_comb begin
    o_sel = SEL_W'(FWD_NONE);
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_sel = SEL_W'(i + 1);
      end
    end
  end

  assign o_hit             = |w_match;
  assign o_load_hit_entry0 = w_match[0] && i_ent0_is_load;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks destination registers in flight between decode and
//               writeback; raises the decode stall and, when forwarding is
//               present, per-operand forward selects. Counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 1,
  parameter int FWD_EN      = 0,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_ADDR_W-1:0]      id_rs_addr,
  input  logic                       id_rs_used,
  input  logic [REG_ADDR_W-1:0]      id_rt_addr,
  input  logic                       id_rt_used,
  input  logic [REG_ADDR_W-1:0]      id_rd_addr,
  input  logic                       id_rd_wr,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rt_sel,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int N_FWD = DEPTH - 1;  // WB entry is never matched

  // Same layout as cpu_pkg::sb_entry_t, sized to this instance's register width
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } entry_t;

  entry_t                      r_entry [DEPTH];
  entry_t                      w_next  [DEPTH];
  logic [CNT_W-1:0]            r_stall_cnt;
  logic [N_FWD-1:0]            w_ent_valid;
  logic [N_FWD*REG_ADDR_W-1:0] w_ent_rd;
  logic                        w_rs_hit, w_rt_hit;
  logic                        w_rs_load0, w_rt_load0;
  logic [SEL_W-1:0]            w_rs_sel, w_rt_sel;
  logic                        w_stall;
  logic                        w_unused;

  // Flatten the matchable entries for the per-operand comparators
  always_comb begin
    w_ent_valid = '0;
    w_ent_rd    = '0;
    for (int i = 0; i < N_FWD; i++) begin
      w_ent_valid[i]                          = r_entry[i].valid;
      w_ent_rd[i*REG_ADDR_W +: REG_ADDR_W]    = r_entry[i].rd;
    end
  end

  sb_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .N_ENT      (N_FWD),
    .SEL_W      (SEL_W)
  ) u_match_rs (
    .i_ent_valid       (w_ent_valid),
    .i_ent_rd          (w_ent_rd),
    .i_ent0_is_load    (r_entry[0].is_load),
    .i_op_addr         (id_rs_addr),
    .i_op_used         (id_rs_used),
    .o_hit             (w_rs_hit),
    .o_load_hit_entry0 (w_rs_load0),
    .o_sel             (w_rs_sel)
  );

  sb_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .N_ENT      (N_FWD),
    .SEL_W      (SEL_W)
  ) u_match_rt (
    .i_ent_valid       (w_ent_valid),
    .i_ent_rd          (w_ent_rd),
    .i_ent0_is_load    (r_entry[0].is_load),
    .i_op_addr         (id_rt_addr),
    .i_op_used         (id_rt_used),
    .o_hit             (w_rt_hit),
    .o_load_hit_entry0 (w_rt_load0),
    .o_sel             (w_rt_sel)
  );

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Only a load still in EX cannot be forwarded in time
      assign w_stall    = id_valid && !flush && (w_rs_load0 || w_rt_load0);
      assign fwd_rs_sel = (w_stall || !id_valid) ? SEL_W'(FWD_NONE) : w_rs_sel;
      assign fwd_rt_sel = (w_stall || !id_valid) ? SEL_W'(FWD_NONE) : w_rt_sel;
    end else begin : g_nofwd
      // Without bypass paths any pending producer blocks decode
      assign w_stall    = id_valid && !flush && (w_rs_hit || w_rt_hit);
      assign fwd_rs_sel = SEL_W'(FWD_NONE);
      assign fwd_rt_sel = SEL_W'(FWD_NONE);
    end
  endgenerate

  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  // Next pipe contents: shift, insert decode (or a bubble), then kill the youngest on flush
  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      w_next[i] = r_entry[i-1];
    end
    w_next[0].valid   = id_valid && id_rd_wr && !w_stall && !flush;
    w_next[0].rd      = id_rd_addr;
    w_next[0].is_load = id_is_load;
    if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        w_next[i].valid = 1'b0;
      end
    end
  end

  // In-flight entry register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= w_next[i];
      end
    end
  end

  // Saturating count of stalled decode cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Comparator outputs not needed by the selected forwarding mode, and the WB entry
  assign w_unused = ^{w_rs_hit, w_rt_hit, w_rs_load0, w_rt_load0,
                      w_rs_sel, w_rt_sel, r_entry[DEPTH-1]};

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed bench for hazard_scoreboard. Three instances share
//               the decode inputs: no-forwarding, forwarding, and a 4-bit
//               stall counter variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_rd_wr, id_is_load, flush;
  logic [2:0] id_rs_addr, id_rt_addr, id_rd_addr;

  logic        stall0, stall1, stall2;
  logic [1:0]  rs0, rt0, rs1, rt1, rs2, rt2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(3), .DEPTH(3), .FLUSH_DEPTH(1), .FWD_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall0), .fwd_rs_sel(rs0), .fwd_rt_sel(rt0),
    .stall_cnt(cnt0));

  hazard_scoreboard #(.REG_ADDR_W(3), .DEPTH(3), .FLUSH_DEPTH(1), .FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall1), .fwd_rs_sel(rs1), .fwd_rt_sel(rt1),
    .stall_cnt(cnt1));

  hazard_scoreboard #(.REG_ADDR_W(3), .DEPTH(3), .FLUSH_DEPTH(1), .FWD_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used), .id_rd_addr(id_rd_addr), .id_rd_wr(id_rd_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall2), .fwd_rs_sel(rs2), .fwd_rt_sel(rt2),
    .stall_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic wr, input logic ld, input logic fl);
    id_valid   = v;
    id_rs_addr = rs;
    id_rs_used = rsu;
    id_rt_addr = rt;
    id_rt_used = rtu;
    id_rd_addr = rd;
    id_rd_wr   = wr;
    id_is_load = ld;
    flush      = fl;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall0", stall0, 0);
    chk("rst_stall1", stall1, 0);
    chk("rst_rs1",    rs1,    0);
    chk("rst_rt1",    rt1,    0);
    chk("rst_cnt0",   cnt0,   0);
    chk("rst_cnt2",   cnt2,   0);
    tick();
    rst = 1'b1;

    // 1: ADDI r1 ; ADD r2,r1,r1 held at decode
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    chk("t1_addi_stall0", stall0, 0);
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0); #2;
    chk("t1_c1_stall0", stall0, 1);
    chk("t1_c1_stall2", stall2, 1);
    chk("t1_c1_stall1", stall1, 0);
    chk("t1_c1_rs1",    rs1,    1);
    chk("t1_c1_rt1",    rt1,    1);
    chk("t1_c1_rs0",    rs0,    0);
    tick(); #2;
    chk("t1_c2_stall0", stall0, 1);
    chk("t1_c2_rs1",    rs1,    2);
    tick(); #2;
    chk("t1_c3_stall0", stall0, 0);
    chk("t1_c3_cnt0",   cnt0,   2);
    chk("t1_c3_cnt2",   cnt2,   2);
    drain();

    // 2: forward from EX, forced-off when decode is empty, forward from MEM
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    tick();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0); #2;
    chk("t2_ex_stall1", stall1, 0);
    chk("t2_ex_rs1",    rs1,    1);
    chk("t2_ex_rt1",    rt1,    0);
    tick();
    drain();
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    tick();
    drive(0, 1, 1, 0, 0, 1, 1, 0, 0); #2;
    chk("t2_novalid_rs1",    rs1,    0);
    chk("t2_novalid_stall0", stall0, 0);
    tick();
    drive(1, 1, 1, 3, 1, 2, 1, 0, 0); #2;
    chk("t2_mem_rs1",    rs1,    2);
    chk("t2_mem_rt1",    rt1,    0);
    chk("t2_mem_stall1", stall1, 0);
    tick();
    drain();

    // 3: load-use stalls once, then forwards from MEM on both operands
    drive(1, 0, 1, 0, 0, 4, 1, 1, 0); #2;
    tick();
    drive(1, 4, 1, 4, 1, 5, 1, 0, 0); #2;
    chk("t3_lu_stall1", stall1, 1);
    chk("t3_lu_rs1",    rs1,    0);
    chk("t3_lu_rt1",    rt1,    0);
    tick(); #2;
    chk("t3_after_stall1", stall1, 0);
    chk("t3_after_rs1",    rs1,    2);
    chk("t3_after_rt1",    rt1,    2);
    tick();
    drain();
    chk("t3_cnt1", cnt1, 1);

    // 4: two producers of r1, youngest wins
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    tick(); #2;
    chk("t4_p2_stall1", stall1, 0);
    tick();
    drive(1, 1, 1, 0, 1, 2, 1, 0, 0); #2;
    chk("t4_rs1",    rs1,    1);
    chk("t4_rt1",    rt1,    0);
    chk("t4_stall1", stall1, 0);
    tick();
    drain();

    // 5: flush beats stall, squashed decode is not inserted, older producer survives
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 1); #2;
    chk("t5_flush_stall0", stall0, 0);
    chk("t5_flush_stall2", stall2, 0);
    chk("t5_flush_rs1",    rs1,    1);
    tick();
    drive(1, 2, 1, 1, 1, 3, 1, 0, 0); #2;
    chk("t5_post_rs1", rs1, 0);
    chk("t5_post_rt1", rt1, 2);
    chk("t5_post_stall1", stall1, 0);
    tick();
    drain();

    // 6: asynchronous reset mid-stall, then counter saturation
    drive(1, 0, 1, 0, 0, 1, 1, 0, 0); #2;
    tick();
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0); #2;
    chk("t6_pre_stall0", stall0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_arst_stall0", stall0, 0);
    chk("t6_arst_cnt0",   cnt0,   0);
    chk("t6_arst_cnt2",   cnt2,   0);
    chk("t6_arst_rs1",    rs1,    0);
    tick();
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 1, 0, 0);
    repeat (30) tick();
    #2;
    chk("t6_cnt0_20",   cnt0,   20);
    chk("t6_cnt2_sat",  cnt2,   15);
    chk("t6_cnt1_zero", cnt1,   0);
    chk("t6_end_stall0", stall0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks destination registers of instructions in flight between decode and writeback for the pipelined WISC-16 core.
- Generates the decode-stage stall and, in forwarding mode, per-operand forward selects.
- Sits beside decode and replaces the implicit "no hazards" assumption of the single-cycle datapath.
- Generalised in register count, pipeline depth, flush reach and forwarding mode, with a stall-cycle counter for performance checks.

Parameters:
- REG_ADDR_W, 3, width of register specifiers (NUM_REGS = 2**REG_ADDR_W).
- DEPTH, 3, in-flight stages tracked after decode (entry 0 = EX, entry DEPTH-1 = WB); legal range 2..6.
- FLUSH_DEPTH, 1, number of youngest entries cleared by flush; legal range 0..DEPTH.
- FWD_EN, 0, 0 = stall on any RAW hazard; 1 = forwarding present, stall only on load-use.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- id_valid  in  1  decode holds a real instruction.
- id_rs_addr  in  REG_ADDR_W  first source register.
- id_rs_used  in  1  instruction reads rs.
- id_rt_addr  in  REG_ADDR_W  second source register.
- id_rt_used  in  1  instruction reads rt.
- id_rd_addr  in  REG_ADDR_W  destination register.
- id_rd_wr  in  1  instruction writes rd.
- id_is_load  in  1  instruction is LD (result available after MEM).
- flush  in  1  branch/jump taken; kill wrong-path instructions.
- stall  out  1  hold PC and IF/ID, insert bubble into EX.
- fwd_rs_sel  out  $clog2(DEPTH+1)  0 = none, k = forward from entry k-1.
- fwd_rt_sel  out  $clog2(DEPTH+1)  same, for rt.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- State: shift register of DEPTH entries {valid, rd, is_load}, plus stall_cnt.
- Reset (rst=0, asynchronous): all entries invalid, stall_cnt=0. Consequently stall=0 and fwd_*_sel=0 combinationally.
- Match rule: entry i matches operand x iff entry valid, and x_used, and entry.rd == x_addr.
  - Entry DEPTH-1 (WB) never matches; the regfile writes before it reads.
- stall, FWD_EN=0: id_valid && flush==0 && any entry 0..DEPTH-2 matches rs or rt.
- stall, FWD_EN=1: id_valid && flush==0 && entry 0 matches rs or rt && entry0.is_load.
- stall is purely combinational, same cycle as the decode inputs.
- fwd_x_sel:
  - FWD_EN=1: smallest matching i in 0..DEPTH-2, encoded i+1, so the youngest producer wins. Forced to 0 whenever stall=1 or id_valid=0.
  - FWD_EN=0: always 0.
- Per clock:
  - entry[i] <= entry[i-1] for i>=1.
  - entry[0] <= {id_valid && id_rd_wr && !stall && !flush, id_rd_addr, id_is_load}, i.e. stall and flush insert a bubble.
- flush:
  - Entries 0..FLUSH_DEPTH-1 become invalid on the next edge, after the shift.
  - Decode is not inserted.
  - flush has priority over stall in the same cycle.
- Simultaneous match in several entries: stall decision unchanged; forwarding selects the youngest.
- rs==rt with both used: both selects identical.
- stall_cnt increments on each clock where stall=1, saturating at all-ones with no wrap.
- Latency: a producer entering at cycle t occupies entry k at cycle t+1+k and leaves after entry DEPTH-1.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W default.
  - typedef sb_entry_t {logic valid; logic [REG_ADDR_W-1:0] rd; logic is_load;}.
  - Constant FWD_NONE = 0.
- One sub-module, sb_match, instantiated twice: combinational match and priority-encode for one operand against all entries, returning hit, load_hit_entry0 and encoded select. The top holds the shift register, stall logic and counter.

Test Plan:
1. FWD_EN=0, DEPTH=3: ADDI r1 at t0, ADD r2,r1,r1 at t1 -> stall=1 at t1,t2, 0 at t3 (producer in WB); stall_cnt=2.
2. FWD_EN=1: ADDI r1 then ADD r2,r1,r3 back-to-back -> stall=0, fwd_rs_sel=1, fwd_rt_sel=0. Same with producer two ahead -> fwd_rs_sel=2.
3. FWD_EN=1: LD r4 then ADD r5,r4,r4 -> stall=1 for exactly one cycle, then fwd_rs_sel=fwd_rt_sel=2.
4. Two producers of r1 at t0 and t1, consumer at t2, FWD_EN=1 -> fwd_rs_sel=1 (youngest).
5. FLUSH_DEPTH=1: ADDI r1 issued, flush next cycle with consumer of r1 at decode -> stall=0; entry 0 invalid after the edge; no later stall from r1.
6. rst driven low mid-stall (asynchronous, between edges) -> stall=0 and stall_cnt=0 immediately. CNT_W=4 held stalled 20 cycles -> stall_cnt saturates at 15.
